// File: rtl/button_evt_pkg.sv
// Shared definitions for the button event arbiter slice.
//   - evt_type codes presented on the event output
//   - per-channel press classifier state encoding
//   - default channel count and long-press length
package button_evt_pkg;

  localparam int DEF_N_BTN   = 4;
  localparam int DEF_LONG_MS = 1000;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_SHORT = 2'b01,
    EVT_LONG  = 2'b10
  } evt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG_SENT
  } press_state_t;

endpackage

// File: rtl/button_press_classifier.sv
// Per-channel press classifier: turns one debounced button level into
// SHORT / LONG press events.
//   clk_1k   : 1 kHz clock, rising edge
//   rst      : synchronous active-high reset
//   btn      : debounced button level, 1 = pressed
//   evt_emit : an event is emitted on this clock edge
//   evt_code : code of the emitted event (EVT_NONE when evt_emit = 0)
module button_press_classifier
  import button_evt_pkg::*;
#(
  parameter int LONG_MS = DEF_LONG_MS,
  parameter int CNT_W   = 10
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic       btn,
  output logic       evt_emit,
  output logic [1:0] evt_code
);

  press_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk_1k) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt holds the number of high samples seen so far in the current press,
  // so reaching LONG_MS-1 while still high means this is the LONG_MS-th sample.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    evt_emit = 1'b0;
    evt_code = EVT_NONE;
    unique case (state)
      ST_IDLE: begin
        if (btn) begin
          state_n = ST_HELD;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn) begin
          state_n  = ST_IDLE;
          evt_emit = 1'b1;
          evt_code = EVT_SHORT;
        end else if (cnt == CNT_W'(LONG_MS - 1)) begin
          state_n  = ST_LONG_SENT;
          evt_emit = 1'b1;
          evt_code = EVT_LONG;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_LONG_SENT: begin
        if (!btn) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: classifies N_BTN debounced buttons into SHORT/LONG
// press events, buffers one pending event per channel and serialises them
// round-robin onto a single valid/ready output.
//   clk_1k    : 1 kHz clock, rising edge
//   rst       : synchronous active-high reset
//   btn_in    : debounced button levels, one bit per channel
//   evt_valid : event present on evt_id / evt_type
//   evt_ready : consumer accepts the event when high with evt_valid
//   evt_id    : channel index of the presented event
//   evt_type  : EVT_SHORT / EVT_LONG, EVT_NONE when idle
//   overrun   : sticky per-channel flag, an event was lost
module button_event_arbiter
  import button_evt_pkg::*;
#(
  parameter int N_BTN   = DEF_N_BTN,
  parameter int LONG_MS = DEF_LONG_MS,
  parameter int CNT_W   = 10
) (
  input  logic                     clk_1k,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_type,
  output logic [N_BTN-1:0]         overrun
);

  localparam int ID_W = $clog2(N_BTN);

  logic [N_BTN-1:0] emit;
  logic [1:0]       code [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_cls
    button_press_classifier #(
      .LONG_MS (LONG_MS),
      .CNT_W   (CNT_W)
    ) u_cls (
      .clk_1k   (clk_1k),
      .rst      (rst),
      .btn      (btn_in[g]),
      .evt_emit (emit[g]),
      .evt_code (code[g])
    );
  end

  logic [N_BTN-1:0] pend_vld;
  evt_type_t        pend_typ [N_BTN];
  logic [N_BTN-1:0] ovr;

  logic             out_vld;
  logic [ID_W-1:0]  out_id;
  evt_type_t        out_typ;
  logic [ID_W-1:0]  rr_ptr;    // first channel searched on the next load

  logic             load;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [N_BTN-1:0] drain;
  int unsigned      cand;

  // Round-robin search starting at rr_ptr, wrapping without a modulo so
  // non-power-of-two channel counts work.
  always_comb begin
    load        = !out_vld || evt_ready;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    drain       = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= N_BTN) cand = cand - N_BTN;
      if (!grant_found && pend_vld[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
    if (load && grant_found) drain[grant_idx] = 1'b1;
  end

  // A new event may replace a pending one only when that pending entry is
  // moving to the output stage on the same edge; otherwise it is lost.
  always_ff @(posedge clk_1k) begin
    if (rst) begin
      pend_vld <= '0;
      ovr      <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) pend_typ[i] <= EVT_NONE;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (emit[i]) begin
          if (pend_vld[i] && !drain[i]) begin
            ovr[i] <= 1'b1;
          end else begin
            pend_vld[i] <= 1'b1;
            pend_typ[i] <= evt_type_t'(code[i]);
          end
        end else if (drain[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_1k) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_id  <= '0;
      out_typ <= EVT_NONE;
      rr_ptr  <= '0;
    end else if (load) begin
      out_vld <= grant_found;
      if (grant_found) begin
        out_id  <= grant_idx;
        out_typ <= pend_typ[grant_idx];
        rr_ptr  <= (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_id  <= '0;
        out_typ <= EVT_NONE;
      end
    end
  end

  assign evt_valid = out_vld;
  assign evt_id    = out_id;
  assign evt_type  = out_typ;
  assign overrun   = ovr;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;
  import button_evt_pkg::*;

  localparam int N_BTN   = 4;
  localparam int LONG_MS = 8;
  localparam int CNT_W   = 10;

  logic             clk_1k = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] btn_in = '0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [1:0]       evt_id;
  logic [1:0]       evt_type;
  logic [N_BTN-1:0] overrun;

  button_event_arbiter #(
    .N_BTN   (N_BTN),
    .LONG_MS (LONG_MS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_1k    (clk_1k),
    .rst       (rst),
    .btn_in    (btn_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .overrun   (overrun)
  );

  always #5 clk_1k = ~clk_1k;

  typedef struct {
    logic [1:0] id;
    logic [1:0] typ;
  } exp_t;

  typedef struct {
    int unsigned ch;
    int unsigned hold;
    logic [1:0]  typ;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[5];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int unsigned id, input logic [1:0] t);
    exp_t e;
    e.id  = 2'(id);
    e.typ = t;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_1k);
    #1;
  endtask

  // Scoreboard side: every accepted handshake must match the oldest expected event.
  always @(negedge clk_1k) begin
    if (!rst) begin
      if (!evt_valid) begin
        chk("idle_type", 32'(evt_type), 32'(EVT_NONE));
      end else if (evt_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got id=%0d type=%0b, expected no event", evt_id, evt_type);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_evt_id", 32'(evt_id), 32'(mon_e.id));
          chk("sb_evt_type", 32'(evt_type), 32'(mon_e.typ));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{ch: 0, hold: 7,  typ: EVT_SHORT};
    vecs[1] = '{ch: 0, hold: 8,  typ: EVT_LONG};
    vecs[2] = '{ch: 3, hold: 1,  typ: EVT_SHORT};
    vecs[3] = '{ch: 2, hold: 12, typ: EVT_LONG};
    vecs[4] = '{ch: 1, hold: 2,  typ: EVT_SHORT};

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_type", 32'(evt_type), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    evt_ready = 1'b1;

    // Short press on channel 2
    push(2, EVT_SHORT);
    btn_in[2] = 1'b1;
    repeat (3) tick();
    btn_in[2] = 1'b0;
    tick();
    chk("short_not_early", 32'(evt_valid), 0);
    tick();
    chk("short_valid", 32'(evt_valid), 1);
    chk("short_id", 32'(evt_id), 2);
    chk("short_type", 32'(evt_type), 32'(EVT_SHORT));
    tick();
    chk("short_one_cycle", 32'(evt_valid), 0);

    // Long press on channel 1, held 20 cycles
    push(1, EVT_LONG);
    btn_in[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 8) chk("long_not_early", 32'(evt_valid), 0);
      if (i == 9) begin
        chk("long_valid", 32'(evt_valid), 1);
        chk("long_id", 32'(evt_id), 1);
        chk("long_type", 32'(evt_type), 32'(EVT_LONG));
      end
      if (i == 10) chk("long_one_cycle", 32'(evt_valid), 0);
    end
    btn_in[1] = 1'b0;
    repeat (4) tick();
    chk("long_release_quiet", 32'(evt_valid), 0);
    chk("long_sb_empty", 32'(sb.size()), 0);

    // Table: hold lengths around the LONG boundary
    for (int k = 0; k < 5; k++) begin
      push(vecs[k].ch, vecs[k].typ);
      btn_in[vecs[k].ch] = 1'b1;
      repeat (vecs[k].hold) tick();
      btn_in[vecs[k].ch] = 1'b0;
      repeat (5) tick();
      chk($sformatf("vec%0d_drain", k), 32'(sb.size()), 0);
    end
    chk("vec_overrun", 32'(overrun), 0);

    // Fairness: all channels at once, twice
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < N_BTN; c++) push(c, EVT_SHORT);
      btn_in = 4'hF;
      tick();
      btn_in = 4'h0;
      tick();
      for (int c = 0; c < N_BTN; c++) begin
        tick();
        chk($sformatf("rr%0d_valid%0d", r, c), 32'(evt_valid), 1);
        chk($sformatf("rr%0d_id%0d", r, c), 32'(evt_id), 32'(c));
      end
      tick();
      chk($sformatf("rr%0d_done", r), 32'(evt_valid), 0);
    end

    // Backpressure: three SHORTs on channel 3 with evt_ready low
    evt_ready = 1'b0;
    btn_in[3] = 1'b1; tick();
    btn_in[3] = 1'b0; tick();
    chk("bp_not_early", 32'(evt_valid), 0);
    for (int s = 0; s < 4; s++) begin
      btn_in[3] = (s % 2 == 0);
      tick();
      chk($sformatf("bp_hold_valid%0d", s), 32'(evt_valid), 1);
      chk($sformatf("bp_hold_id%0d", s), 32'(evt_id), 3);
      chk($sformatf("bp_hold_type%0d", s), 32'(evt_type), 32'(EVT_SHORT));
    end
    chk("bp_overrun", 32'(overrun), 32'h8);
    push(3, EVT_SHORT);
    push(3, EVT_SHORT);
    evt_ready = 1'b1;
    tick();
    chk("bp_second_valid", 32'(evt_valid), 1);
    chk("bp_second_id", 32'(evt_id), 3);
    tick();
    chk("bp_empty_after_two", 32'(evt_valid), 0);
    repeat (3) tick();
    chk("bp_sb_empty", 32'(sb.size()), 0);
    chk("bp_overrun_sticky", 32'(overrun), 32'h8);

    // Reset while channel 0 is held and events are in flight
    evt_ready = 1'b0;
    btn_in = 4'b0110; tick();
    btn_in = 4'b0000; tick();
    tick();
    btn_in[0] = 1'b1;
    tick();
    chk("mid_pre_valid", 32'(evt_valid), 1);
    chk("mid_pre_id", 32'(evt_id), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_type", 32'(evt_type), 0);
    rst = 1'b0;
    evt_ready = 1'b1;
    tick();
    tick();
    push(0, EVT_SHORT);
    btn_in[0] = 1'b0;
    tick();
    chk("mid_new_not_early", 32'(evt_valid), 0);
    tick();
    chk("mid_new_valid", 32'(evt_valid), 1);
    chk("mid_new_id", 32'(evt_id), 0);
    chk("mid_new_type", 32'(evt_type), 32'(EVT_SHORT));
    repeat (4) tick();
    chk("mid_no_stale", 32'(evt_valid), 0);

    repeat (3) tick();
    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
